// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready inter-stage pipeline register with a 2-entry skid buffer.
// The main slot drives the outputs. The skid slot catches the one entry that can
// arrive while the downstream stage stalls. Because of this, in_ready is a plain
// flop and back-pressure never forms a combinational path.
// Invalid slots always hold all-zero control, so bubbles reach downstream as NOPs.
// Optional feature macro: PIPE_STAGE_SKID_STALL_CNT_EN adds a saturating 32-bit
// stall_cycles counter output.
module pipe_stage_skid #(
  parameter int unsigned DATA_W   = 96,
  parameter int unsigned CTRL_W   = 8,
  parameter bit          RST_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  // Bit 0 is the main-slot valid and bit 1 is the skid-slot valid.
  // The encoding 2'b10 (skid valid without main valid) is never produced.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic              w_accept;
  logic              w_pop;
  logic              w_ld_main_in;
  logic              w_ld_main_skid;
  logic              w_ld_skid_in;

  // Main slot holds a live entry in this state.
  function automatic logic f_main_valid(input state_t s);
    return s[0];
  endfunction

  // Skid slot holds a live entry in this state.
  function automatic logic f_skid_valid(input state_t s);
    return s[1];
  endfunction

  assign w_accept  = in_valid & r_in_ready;
  assign w_pop     = f_main_valid(r_state) & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = f_main_valid(r_state);
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;

  // Next-state and slot-load decisions; flush overrides every handshake.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid_in   = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end else begin
            w_state_nxt  = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt  = ST_FULL;
            w_ld_skid_in = 1'b1;
          end else if (w_pop) begin
            w_state_nxt  = ST_EMPTY;
          end else begin
            w_state_nxt  = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (w_pop) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end else begin
            w_state_nxt    = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Next data: load from input or promote skid to main; otherwise hold (flush does not touch data).
  always_comb begin
    w_main_data_nxt = r_main_data;
    w_skid_data_nxt = r_skid_data;
    if (w_ld_main_in) begin
      w_main_data_nxt = in_data;
    end else if (w_ld_main_skid) begin
      w_main_data_nxt = r_skid_data;
    end else begin
      w_main_data_nxt = r_main_data;
    end
    if (w_ld_skid_in) begin
      w_skid_data_nxt = in_data;
    end else begin
      w_skid_data_nxt = r_skid_data;
    end
  end

  // Next control: any slot that will be invalid carries all-zero control.
  always_comb begin
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_ctrl_nxt = r_skid_ctrl;
    if (!f_main_valid(w_state_nxt)) begin
      w_main_ctrl_nxt = {CTRL_W{1'b0}};
    end else if (w_ld_main_in) begin
      w_main_ctrl_nxt = in_ctrl;
    end else if (w_ld_main_skid) begin
      w_main_ctrl_nxt = r_skid_ctrl;
    end else begin
      w_main_ctrl_nxt = r_main_ctrl;
    end
    if (!f_skid_valid(w_state_nxt)) begin
      w_skid_ctrl_nxt = {CTRL_W{1'b0}};
    end else if (w_ld_skid_in) begin
      w_skid_ctrl_nxt = in_ctrl;
    end else begin
      w_skid_ctrl_nxt = r_skid_ctrl;
    end
  end

  // State, control and ready registers; reset empties the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= ~f_skid_valid(w_state_nxt);
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  // Data registers; they are cleared by reset only when RST_DATA is set.
  always_ff @(posedge clk) begin
    if (rst && RST_DATA) begin
      r_main_data <= {DATA_W{1'b0}};
      r_skid_data <= {DATA_W{1'b0}};
    end else begin
      r_main_data <= w_main_data_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating increment: the counter stops at all-ones.
  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  // Count cycles in which a live head entry is held off by downstream; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (f_main_valid(r_state) && !out_ready) begin
      r_stall_cnt <= f_sat_inc(r_stall_cnt);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule
